// File: rtl/sdram_march_tester.sv
// Write/verify march tester for the SDRAM port: writes main+aux banks over an address
// range, reads both back and compares, in a true-data pass then an inverted-data pass.
module sdram_march_tester #(
  parameter logic [20:0] ADDR_FIRST  = 21'h000000,
  parameter logic [20:0] ADDR_LAST   = 21'h0000FF,
  parameter int          HOLD_CYCLES = 2
) (
  input  logic        clk14M,
  input  logic        reset,
  input  logic        ready14M,
  input  logic        start,
  input  logic [15:0] sdram_dout,
  output logic [20:0] sdram_addr,
  output logic [7:0]  sdram_din,
  output logic        sdram_we,
  output logic        sdram_aux,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [20:0] err_addr,
  output logic [15:0] err_expected,
  output logic [15:0] err_got
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_READY, S_WR_MAIN, S_WR_AUX, S_RD, S_DONE, S_FAIL
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  // {aux,main} data for address a in pass p; pass 1 is the bitwise inverse
  function automatic logic [15:0] pattern(input logic [20:0] a, input logic p);
    logic [7:0] m, x;
    m = a[7:0] ^ a[15:8] ^ {3'b0, a[20:16]} ^ 8'hA5;
    x = {m[3:0], m[7:4]} ^ 8'h3C;
    return p ? {~x, ~m} : {x, m};
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [20:0] a_q, a_d;
  logic        pass_q, pass_d;
  logic [20:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic        we_q, we_d, aux_q, aux_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [20:0] err_addr_q, err_addr_d;
  logic [15:0] err_exp_q, err_exp_d, err_got_q, err_got_d;
  logic [15:0] exp_rd, nxt_pat;
  logic        phase_end;

  always_ff @(posedge clk14M or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      a_q        <= '0;
      pass_q     <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      we_q       <= 1'b0;
      aux_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      a_q        <= a_d;
      pass_q     <= pass_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      we_q       <= we_d;
      aux_q      <= aux_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
      err_exp_q  <= err_exp_d;
      err_got_q  <= err_got_d;
    end
  end

  // ready14M low freezes the hold counter, so no phase ends and no compare happens
  assign phase_end = ready14M && (hold_q == HOLD_LAST);
  assign exp_rd    = pattern(a_q, pass_q);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    a_d        = a_q;
    pass_d     = pass_q;
    done_d     = done_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d    = S_WAIT_READY;
          hold_d     = '0;
          a_d        = ADDR_FIRST;
          pass_d     = 1'b0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_addr_d = '0;
          err_exp_d  = '0;
          err_got_d  = '0;
        end
      end
      S_WAIT_READY: begin
        if (ready14M) begin
          state_d = S_WR_MAIN;
          hold_d  = '0;
        end
      end
      S_WR_MAIN, S_WR_AUX, S_RD: begin
        if (ready14M && !phase_end) hold_d = hold_q + 8'd1;
        if (phase_end) begin
          hold_d = '0;
          if (state_q == S_WR_MAIN) begin
            state_d = S_WR_AUX;
          end else if (state_q == S_WR_AUX) begin
            if (a_q == ADDR_LAST) begin
              a_d     = ADDR_FIRST;
              state_d = S_RD;
            end else begin
              a_d     = a_q + 21'd1;
              state_d = S_WR_MAIN;
            end
          end else if (sdram_dout != exp_rd) begin
            state_d    = S_FAIL;
            error_d    = 1'b1;
            err_addr_d = a_q;
            err_exp_d  = exp_rd;
            err_got_d  = sdram_dout;
          end else if (a_q != ADDR_LAST) begin
            a_d = a_q + 21'd1;
          end else if (!pass_q) begin
            pass_d  = 1'b1;
            a_d     = ADDR_FIRST;
            state_d = S_WR_MAIN;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // bus registers are loaded from the next state so they change on the edge entering a phase
  always_comb begin
    addr_d  = '0;
    din_d   = '0;
    we_d    = 1'b0;
    aux_d   = 1'b0;
    nxt_pat = pattern(a_d, pass_d);
    busy_d  = state_d inside {S_WAIT_READY, S_WR_MAIN, S_WR_AUX, S_RD};
    case (state_d)
      S_WR_MAIN: begin
        addr_d = a_d;
        din_d  = nxt_pat[7:0];
        we_d   = 1'b1;
      end
      S_WR_AUX: begin
        addr_d = a_d;
        din_d  = nxt_pat[15:8];
        we_d   = 1'b1;
        aux_d  = 1'b1;
      end
      S_RD:    addr_d = a_d;
      default: ;
    endcase
  end

  assign sdram_addr   = addr_q;
  assign sdram_din    = din_q;
  assign sdram_we     = we_q;
  assign sdram_aux    = aux_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_addr     = err_addr_q;
  assign err_expected = err_exp_q;
  assign err_got      = err_got_q;

endmodule

// File: tb/tb_sdram_march_tester.sv
// Bench for sdram_march_tester: behavioural SDRAM with optional corruption, a queue of
// expected per-cycle bus values built from the march rules, and a negedge bus monitor.
module tb_sdram_march_tester;

  localparam logic [20:0] AF = 21'h0;
  localparam logic [20:0] AL = 21'h3;
  localparam int          H  = 2;

  typedef struct packed {
    logic [20:0] addr;
    logic [7:0]  din;
    logic        we;
    logic        aux;
  } bus_t;

  logic        clk14M = 1'b0;
  logic        reset = 1'b1;
  logic        ready14M = 1'b1;
  logic        start = 1'b0;
  logic [15:0] sdram_dout;
  logic [20:0] sdram_addr;
  logic [7:0]  sdram_din;
  logic        sdram_we, sdram_aux;
  logic        busy, done, error;
  logic [20:0] err_addr;
  logic [15:0] err_expected, err_got;

  int tests = 0;
  int fails = 0;
  bus_t exp_q[$];

  logic [7:0] mem_main[16];
  logic [7:0] mem_aux[16];
  logic       corrupt_en = 1'b0;
  logic [3:0] c_addr = '0;
  logic       c_bank = 1'b0;
  logic [7:0] c_mask = '0;

  always #5 clk14M = ~clk14M;

  sdram_march_tester #(.ADDR_FIRST(AF), .ADDR_LAST(AL), .HOLD_CYCLES(H)) dut (
    .clk14M(clk14M), .reset(reset), .ready14M(ready14M), .start(start),
    .sdram_dout(sdram_dout), .sdram_addr(sdram_addr), .sdram_din(sdram_din),
    .sdram_we(sdram_we), .sdram_aux(sdram_aux), .busy(busy), .done(done),
    .error(error), .err_addr(err_addr), .err_expected(err_expected), .err_got(err_got)
  );

  // behavioural SDRAM: writes land on the clock edge, reads are combinational
  always @(posedge clk14M) begin
    if (sdram_we) begin
      if (sdram_aux)
        mem_aux[sdram_addr[3:0]] <= sdram_din ^
          ((corrupt_en && c_bank && sdram_addr[3:0] == c_addr) ? c_mask : 8'h00);
      else
        mem_main[sdram_addr[3:0]] <= sdram_din ^
          ((corrupt_en && !c_bank && sdram_addr[3:0] == c_addr) ? c_mask : 8'h00);
    end
  end
  assign sdram_dout = {mem_aux[sdram_addr[3:0]], mem_main[sdram_addr[3:0]]};

  function automatic logic [15:0] pat(input logic [20:0] a, input logic p);
    logic [7:0] m, x;
    m = a[7:0] ^ a[15:8] ^ {3'b0, a[20:16]} ^ 8'hA5;
    x = {m[3:0], m[7:4]} ^ 8'h3C;
    return p ? {~x, ~m} : {x, m};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // one queue entry per advancing cycle: a wait-ready cycle, then H cycles per access
  task automatic plan(input int fail_addr, output int cnt);
    logic [15:0] d;
    cnt = 1;
    exp_q.push_back('0);
    for (int p = 0; p < 2; p++) begin
      for (int a = int'(AF); a <= int'(AL); a++) begin
        d = pat(21'(a), p[0]);
        repeat (H) exp_q.push_back({21'(a), d[7:0], 1'b1, 1'b0});
        repeat (H) exp_q.push_back({21'(a), d[15:8], 1'b1, 1'b1});
        cnt += 2 * H;
      end
      for (int a = int'(AF); a <= int'(AL); a++) begin
        repeat (H) exp_q.push_back({21'(a), 8'h00, 1'b0, 1'b0});
        cnt += H;
        if (a == fail_addr) return;
      end
    end
  endtask

  always @(negedge clk14M) begin
    bus_t cur;
    cur = {sdram_addr, sdram_din, sdram_we, sdram_aux};
    if (!reset && busy) begin
      if (exp_q.size() == 0) begin
        chk("bus_extra", 128'(cur), 128'hDEAD);
      end else begin
        chk(ready14M ? "bus" : "bus_frozen", 128'(cur), 128'(exp_q[0]));
        if (ready14M) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk14M);
    #1;
  endtask

  task automatic do_run(input int fail_addr, input logic bank, input logic [7:0] mask,
                        input int stall_len, input bit stall_rand, input bit pulse_start,
                        input int abort_at);
    int cnt, stall_at, n;
    logic [15:0] e;
    corrupt_en = (fail_addr >= 0);
    c_addr = 4'(fail_addr);
    c_bank = bank;
    c_mask = mask;
    plan(fail_addr, cnt);
    stall_at = stall_rand ? int'($urandom_range(0, cnt - 1)) : 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clear", {busy, done, error, err_addr, err_expected, err_got},
        {1'b1, 1'b0, 1'b0, 21'h0, 16'h0, 16'h0});
    n = 0;
    forever begin
      ready14M = !(n >= stall_at && n < stall_at + stall_len);
      start = pulse_start && (n == 10);
      if (abort_at > 0 && n == abort_at) begin
        #1 reset = 1'b1;
        #1 chk("async_reset", {busy, done, error, err_addr, err_expected, err_got,
                               sdram_addr, sdram_din, sdram_we, sdram_aux}, '0);
        exp_q.delete();
        start = 1'b0;
        ready14M = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        return;
      end
      tick();
      n++;
      if (!busy) break;
      if (n > 400) begin
        chk("timeout", 128'(n), 128'(cnt + stall_len));
        break;
      end
    end
    start = 1'b0;
    ready14M = 1'b1;
    chk("run_cycles", 128'(n), 128'(cnt + stall_len));
    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
    if (fail_addr >= 0) begin
      e = pat(21'(fail_addr), 1'b0);
      chk("flags", {done, error}, 2'b01);
      chk("err_addr", 128'(err_addr), 128'(fail_addr));
      chk("err_expected", 128'(err_expected), 128'(e));
      chk("err_got", 128'(err_got), 128'(e ^ (bank ? {mask, 8'h00} : {8'h00, mask})));
    end else begin
      chk("flags", {done, error}, 2'b10);
      chk("err_fields", {err_addr, err_expected, err_got}, '0);
    end
    chk("idle_bus", {busy, sdram_addr, sdram_din, sdram_we, sdram_aux}, '0);
    tick();
    chk("sticky", {done, error}, (fail_addr >= 0) ? 2'b01 : 2'b10);
  endtask

  initial begin
    #2;
    chk("reset_state", {busy, done, error, err_addr, err_expected, err_got,
                        sdram_addr, sdram_din, sdram_we, sdram_aux}, '0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_after_reset", {busy, sdram_addr, sdram_we}, '0);
    do_run(-1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 0);        // ideal run
    do_run(-1, 1'b0, 8'h00, 5, 1'b0, 1'b0, 0);        // 5-cycle stall inside WR_AUX
    do_run(2, 1'b1, 8'h10, 0, 1'b0, 1'b0, 0);         // aux of A=2 corrupted
    do_run(-1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 0);        // restart from FAIL, start while busy
    do_run(-1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 20);       // reset mid read phase
    do_run(-1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      int fa;
      fa = int'($urandom_range(0, 4));
      if (fa == 4) fa = -1;
      do_run(fa, 1'($urandom_range(0, 1)), 8'($urandom_range(1, 255)),
             int'($urandom_range(0, 6)), 1'b1, 1'($urandom_range(0, 1)), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
